// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: FSM state
// encoding, scoreboard entry layout and the register-match helper.
package pipe_pkg;

    // Register index storage width inside the scoreboard. Wide enough for any
    // REG_BITS up to 8; narrower indices are zero-extended on entry.
    localparam int REG_BITS_MAX = 8;

    typedef logic [REG_BITS_MAX-1:0] sb_rd_t;

    // x0 is hard-wired zero and never produces a forwardable value.
    localparam sb_rd_t REG_ZERO = '0;

    // Forwarding select value meaning "read the register file".
    localparam int SEL_REGFILE = 0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        BRWAIT = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic   valid;
        sb_rd_t rd;
        logic   is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: '0, is_load: 1'b0};

    // True when a scoreboard entry produces the (nonzero) source register rs.
    function automatic logic sb_match(input sb_entry_t entry, input sb_rd_t rs);
        return entry.valid && (entry.rd == rs) && (rs != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational priority matcher: returns the youngest scoreboard stage that
// writes the requested source register, or the register-file select.
import pipe_pkg::*;

module fwd_match #(
    parameter int STAGES = 3,
    parameter int SEL_W  = 2
) (
    input  sb_rd_t                  rs,
    input  sb_entry_t [STAGES:1]    sb,
    output logic      [SEL_W-1:0]   sel
);

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        sel = SEL_W'(SEL_REGFILE);
        for (int k = STAGES; k >= 1; k--) begin
            if (sb_match(sb[k], rs)) begin
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller between ID and the downstream stages.
// Tracks in-flight writers in a shift-register scoreboard, produces per-operand
// forwarding selects, stalls on load-use and sequences control hazards.
// Build option: define PIPE_HAZARD_PRED_NT_EN for predict-not-taken with flush;
// otherwise branches stall ID until resolved (stall-until-resolve).
//
// Handshake note: there is no valid/ready pair here. i_stall_ext freezes all
// state; o_stall_fetch/o_bubble_id are combinational requests for the same cycle.
import pipe_pkg::*;

module pipe_hazard_ctrl #(
    parameter int REG_BITS   = 5,
    parameter int FWD_STAGES = 3,
    parameter int BR_LAT     = 3,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_id_valid,
    input  logic [REG_BITS-1:0] i_id_rs1,
    input  logic [REG_BITS-1:0] i_id_rs2,
    input  logic [REG_BITS-1:0] i_id_rd,
    input  logic                i_id_reg_write,
    input  logic                i_id_mem_read,
    input  logic                i_id_branch,
    input  logic                i_redirect,
    input  logic                i_stall_ext,
    output logic                o_stall_fetch,
    output logic                o_bubble_id,
    output logic                o_flush,
    output logic [SEL_W-1:0]    o_fwd_rs1_sel,
    output logic [SEL_W-1:0]    o_fwd_rs2_sel,
    output logic                o_busy
);

    localparam int CNT_W = $clog2(BR_LAT + 1);

    sb_entry_t [FWD_STAGES:1] sb;
    sb_entry_t [FWD_STAGES:1] sb_nxt;
    fsm_state_t               state;
    fsm_state_t               state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;

    logic   stall;
    logic   bubble;
    logic   flush;
    logic   clear_wp;
    logic   load_use;
    logic   issue;
    sb_rd_t rs1_x;
    sb_rd_t rs2_x;
    sb_rd_t rd_x;

    assign rs1_x = sb_rd_t'(i_id_rs1);
    assign rs2_x = sb_rd_t'(i_id_rs2);
    assign rd_x  = sb_rd_t'(i_id_rd);

    // A load in the youngest slot cannot forward yet; its consumer must wait a cycle.
    assign load_use = sb[1].is_load && (sb_match(sb[1], rs1_x) || sb_match(sb[1], rs2_x));

    assign issue = i_id_valid && !bubble && i_id_reg_write && (rd_x != REG_ZERO);

    // Stall/bubble/flush decisions and FSM next state, in priority order
    // ext stall > redirect > load-use > branch issue.
    always_comb begin
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        clear_wp  = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_stall_ext) begin
            stall = 1'b1;
        end else begin
`ifdef PIPE_HAZARD_PRED_NT_EN
            if (i_redirect) begin
                flush     = 1'b1;
                bubble    = 1'b1;
                clear_wp  = 1'b1;
                state_nxt = RUN;
            end else if (load_use) begin
                stall     = 1'b1;
                bubble    = 1'b1;
                state_nxt = LDUSE;
            end else begin
                state_nxt = RUN;
            end
`else
            case (state)
                BRWAIT: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (i_redirect || (cnt == CNT_W'(1))) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                // LDUSE re-presents the held consumer, which may itself be a branch.
                default: begin
                    if (load_use) begin
                        stall     = 1'b1;
                        bubble    = 1'b1;
                        state_nxt = LDUSE;
                    end else if (i_id_valid && i_id_branch) begin
                        state_nxt = BRWAIT;
                        cnt_nxt   = CNT_W'(BR_LAT);
                    end else begin
                        state_nxt = RUN;
                    end
                end
            endcase
`endif
        end
    end

    // Scoreboard shift; on a flush the wrong-path slots are emptied as they move.
    always_comb begin
        sb_nxt[1] = issue ? '{valid: 1'b1, rd: rd_x, is_load: i_id_mem_read} : SB_EMPTY;
        for (int k = 2; k <= FWD_STAGES; k++) begin
            sb_nxt[k] = (clear_wp && (k <= BR_LAT)) ? SB_EMPTY : sb[k-1];
        end
    end

    // State registers; everything holds while the pipeline is frozen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sb    <= '0;
            state <= RUN;
            cnt   <= '0;
        end else if (!i_stall_ext) begin
            sb    <= sb_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    fwd_match #(.STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_fwd_rs1 (
        .rs  (rs1_x),
        .sb  (sb),
        .sel (o_fwd_rs1_sel)
    );

    fwd_match #(.STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_fwd_rs2 (
        .rs  (rs2_x),
        .sb  (sb),
        .sel (o_fwd_rs2_sel)
    );

    // Control outputs are forced low while reset is asserted.
    assign o_stall_fetch = stall  && !i_rst;
    assign o_bubble_id   = bubble && !i_rst;
    assign o_flush       = flush  && !i_rst;
    assign o_busy        = (state != RUN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with an expected-value queue and
// an independent monitor that compares once per cycle on the falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_branch;
  logic       redirect;
  logic       stall_ext;
  logic       stall_fetch;
  logic       bubble_id;
  logic       flush;
  logic [1:0] fwd_rs1_sel;
  logic [1:0] fwd_rs2_sel;
  logic       busy;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  // clock
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_BITS(5), .FWD_STAGES(3), .BR_LAT(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_rd        (id_rd),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_read  (id_mem_read),
    .i_id_branch    (id_branch),
    .i_redirect     (redirect),
    .i_stall_ext    (stall_ext),
    .o_stall_fetch  (stall_fetch),
    .o_bubble_id    (bubble_id),
    .o_flush        (flush),
    .o_fwd_rs1_sel  (fwd_rs1_sel),
    .o_fwd_rs2_sel  (fwd_rs2_sel),
    .o_busy         (busy)
  );

  // expected packing: {stall, bubble, flush, busy, rs1_sel, rs2_sel}
  function automatic logic [7:0] e(input logic st, input logic bb, input logic fl,
                                   input logic bz, input logic [1:0] s1, input logic [1:0] s2);
    return {st, bb, fl, bz, s1, s2};
  endfunction

  // driver: apply one ID cycle, queue its expected response, advance a cycle
  task automatic cyc(input string nm, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic br,
                     input logic rdr, input logic sx, input logic [7:0] exp_v);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_branch    = br;
    redirect     = rdr;
    stall_ext    = sx;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [7:0] exp_v;
      logic [7:0] act_v;
      string      nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {stall_fetch, bubble_id, flush, busy, fwd_rs1_sel, fwd_rs2_sel};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: actual {stall,bubble,flush,busy,sel1,sel2}=%b_%b_%b_%b_%0d_%0d required %b_%b_%b_%b_%0d_%0d",
                 nm, act_v[7], act_v[6], act_v[5], act_v[4], act_v[3:2], act_v[1:0],
                 exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:2], exp_v[1:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_branch = 1'b0;
    redirect = 1'b0; stall_ext = 1'b0;
    @(posedge clk);
    #1;
    // reset state: outputs low even with stall_ext and a live instruction applied
    cyc("reset", 1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 1, e(0,0,0,0,0,0));
    rst = 1'b0;

    // forwarding
    cyc("addi_x5",        1, 5'd0,  5'd0,  5'd5,  1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("raw_b2b",        1, 5'd5,  5'd5,  5'd6,  1, 0, 0, 0, 0, e(0,0,0,0,1,1));
    cyc("raw_two_stages", 1, 5'd5,  5'd6,  5'd10, 1, 0, 0, 0, 0, e(0,0,0,0,2,1));
    cyc("nop",            0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("raw_after_nop",  1, 5'd10, 5'd6,  5'd11, 1, 0, 0, 0, 0, e(0,0,0,0,2,3));
    // load-use on rs1
    cyc("lw_x7",          1, 5'd0,  5'd0,  5'd7,  1, 1, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("load_use_rs1",   1, 5'd7,  5'd0,  5'd8,  1, 0, 0, 0, 0, e(1,1,0,0,1,0));
    cyc("load_use_after", 1, 5'd7,  5'd0,  5'd8,  1, 0, 0, 0, 0, e(0,0,0,1,2,0));
    // x0 never tracked or forwarded
    cyc("lw_x0",          1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("use_x0",         1, 5'd0,  5'd0,  5'd9,  1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    // youngest producer wins
    cyc("wr_x12",         1, 5'd0,  5'd0,  5'd12, 1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("wr_x9_again",    1, 5'd0,  5'd12, 5'd9,  1, 0, 0, 0, 0, e(0,0,0,0,0,1));
    cyc("youngest_wins",  1, 5'd9,  5'd12, 5'd13, 1, 0, 0, 0, 0, e(0,0,0,0,1,2));
    // load-use on rs2
    cyc("lw_x14",         1, 5'd13, 5'd0,  5'd14, 1, 1, 0, 0, 0, e(0,0,0,0,1,0));
    cyc("load_use_rs2",   1, 5'd0,  5'd14, 5'd0,  0, 0, 0, 0, 0, e(1,1,0,0,0,1));
    cyc("load_use2_after",1, 5'd0,  5'd14, 5'd0,  0, 0, 0, 0, 0, e(0,0,0,1,0,2));
    // external stall while running
    cyc("ext_stall_run",  1, 5'd14, 5'd0,  5'd17, 1, 0, 0, 1, 1, e(1,0,0,0,3,0));
    cyc("ext_stall_done", 1, 5'd14, 5'd0,  5'd17, 1, 0, 0, 0, 0, e(0,0,0,0,3,0));

`ifndef PIPE_HAZARD_PRED_NT_EN
    // branch: three wait cycles
    cyc("br_issue",       1, 5'd17, 5'd0,  5'd0,  0, 0, 1, 0, 0, e(0,0,0,0,1,0));
    cyc("br_wait1",       1, 5'd17, 5'd0,  5'd15, 1, 0, 0, 0, 0, e(1,1,0,1,2,0));
    cyc("br_wait2",       1, 5'd17, 5'd0,  5'd15, 1, 0, 0, 0, 0, e(1,1,0,1,3,0));
    cyc("br_wait3",       1, 5'd17, 5'd0,  5'd15, 1, 0, 0, 0, 0, e(1,1,0,1,0,0));
    cyc("br_resume",      1, 5'd17, 5'd0,  5'd15, 1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    // branch: redirect on second wait cycle
    cyc("br2_issue",      1, 5'd15, 5'd0,  5'd0,  0, 0, 1, 0, 0, e(0,0,0,0,1,0));
    cyc("br2_wait1",      1, 5'd15, 5'd0,  5'd16, 1, 0, 0, 0, 0, e(1,1,0,1,2,0));
    cyc("br2_redirect",   1, 5'd15, 5'd0,  5'd16, 1, 0, 0, 1, 0, e(1,1,0,1,3,0));
    cyc("br2_resume",     1, 5'd15, 5'd0,  5'd16, 1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    // branch: external stall freezes counter, scoreboard, ignores redirect
    cyc("br3_issue",      1, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, e(0,0,0,0,0,0));
    cyc("br3_wait1",      1, 5'd16, 5'd0,  5'd18, 1, 0, 0, 0, 0, e(1,1,0,1,2,0));
    for (int i = 0; i < 4; i++) begin
      cyc("br3_frozen",   1, 5'd16, 5'd0,  5'd18, 1, 0, 0, 1, 1, e(1,0,0,1,3,0));
    end
    cyc("br3_wait2",      1, 5'd16, 5'd0,  5'd18, 1, 0, 0, 0, 0, e(1,1,0,1,3,0));
    cyc("br3_wait3",      1, 5'd16, 5'd0,  5'd18, 1, 0, 0, 0, 0, e(1,1,0,1,0,0));
    cyc("br3_resume",     1, 5'd16, 5'd0,  5'd18, 1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    // asynchronous reset in the middle of a branch wait
    cyc("br4_issue",      1, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, e(0,0,0,0,0,0));
    cyc("br4_wait1",      1, 5'd18, 5'd0,  5'd0,  0, 0, 0, 0, 0, e(1,1,0,1,2,0));
    rst = 1'b1;
    cyc("async_rst",      1, 5'd18, 5'd0,  5'd0,  0, 0, 0, 0, 0, e(0,0,0,0,0,0));
    rst = 1'b0;
    cyc("post_rst_run",   1, 5'd18, 5'd0,  5'd0,  0, 0, 0, 0, 0, e(0,0,0,0,0,0));
`else
    // predict-not-taken: wrong-path writers flushed on redirect
    cyc("nt_br_issue",    1, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, e(0,0,0,0,0,0));
    cyc("nt_wp_x3",       1, 5'd0,  5'd0,  5'd3,  1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("nt_wp_x4",       1, 5'd0,  5'd0,  5'd4,  1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("nt_redirect",    1, 5'd3,  5'd4,  5'd20, 1, 0, 0, 1, 0, e(0,1,1,0,2,1));
    cyc("nt_x3_gone",     1, 5'd3,  5'd4,  5'd21, 1, 0, 0, 0, 0, e(0,0,0,0,0,0));
    // redirect cancels a simultaneous load-use stall
    cyc("nt_lw_x7",       1, 5'd0,  5'd0,  5'd7,  1, 1, 0, 0, 0, e(0,0,0,0,0,0));
    cyc("nt_ldu_cancel",  1, 5'd7,  5'd0,  5'd8,  1, 0, 0, 1, 0, e(0,1,1,0,1,0));
    cyc("nt_x7_gone",     1, 5'd7,  5'd0,  5'd8,  1, 0, 0, 0, 0, e(0,0,0,0,0,0));
`endif

    // drain: bounded wait for the monitor to consume every expectation
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
